// File: rtl/fifo_lanes4.sv
// rtl/fifo_lanes4.sv - four independent circular-buffer lanes with status flags and aggregate pause
// Optional overflow/underflow latching is enabled with FIFO_ERR_DETECT_EN.
module fifo_lanes4 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AF_TH  = 3,
    parameter int AE_TH  = 1
) (
    input  logic              clk_1,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] dataIn0,
    input  logic [DATA_W-1:0] dataIn1,
    input  logic [DATA_W-1:0] dataIn2,
    input  logic [DATA_W-1:0] dataIn3,
    input  logic              push0,
    input  logic              push1,
    input  logic              push2,
    input  logic              push3,
    input  logic              pop0,
    input  logic              pop1,
    input  logic              pop2,
    input  logic              pop3,
    output logic [DATA_W-1:0] dataOut0,
    output logic [DATA_W-1:0] dataOut1,
    output logic [DATA_W-1:0] dataOut2,
    output logic [DATA_W-1:0] dataOut3,
    output logic              validOut0,
    output logic              validOut1,
    output logic              validOut2,
    output logic              validOut3,
    output logic [3:0]        full,
    output logic [3:0]        empty,
    output logic [3:0]        almost_full,
    output logic [3:0]        almost_empty,
    output logic              pause,
    output logic [3:0]        err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_TH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_TH);

    logic [DATA_W-1:0] din [4];
    logic [3:0]        push;
    logic [3:0]        pop;

    logic [DATA_W-1:0] mem_q  [4][DEPTH];
    logic [DATA_W-1:0] mem_d  [4][DEPTH];
    logic [PW-1:0]     wr_q   [4];
    logic [PW-1:0]     wr_d   [4];
    logic [PW-1:0]     rd_q   [4];
    logic [PW-1:0]     rd_d   [4];
    logic [CW-1:0]     cnt_q  [4];
    logic [CW-1:0]     cnt_d  [4];
    logic [DATA_W-1:0] dout_q [4];
    logic [DATA_W-1:0] dout_d [4];
    logic [3:0]        valid_q;
    logic [3:0]        valid_d;
    logic [3:0]        push_ok;
    logic [3:0]        pop_ok;

    always_comb begin
        din[0] = dataIn0;
        din[1] = dataIn1;
        din[2] = dataIn2;
        din[3] = dataIn3;
    end

    assign push = {push3, push2, push1, push0};
    assign pop  = {pop3, pop2, pop1, pop0};

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = '0;
        push_ok = '0;
        pop_ok  = '0;
        for (int i = 0; i < 4; i++) begin
            pop_ok[i]  = pop[i] && (cnt_q[i] != '0);
            // A full lane still takes a push when the same-cycle pop frees a slot.
            push_ok[i] = push[i] && ((cnt_q[i] != CNT_FULL) || pop_ok[i]);
            if (pop_ok[i]) begin
                dout_d[i]  = mem_q[i][rd_q[i]];
                rd_d[i]    = rd_q[i] + PW'(1);
                valid_d[i] = 1'b1;
            end
            if (push_ok[i]) begin
                mem_d[i][wr_q[i]] = din[i];
                wr_d[i]           = wr_q[i] + PW'(1);
            end
            cnt_d[i] = cnt_q[i] + CW'(push_ok[i]) - CW'(pop_ok[i]);
        end
    end

    always_ff @(posedge clk_1 or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                wr_q[i]   <= '0;
                rd_q[i]   <= '0;
                cnt_q[i]  <= '0;
                dout_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        full         = '0;
        empty        = '0;
        almost_full  = '0;
        almost_empty = '0;
        for (int i = 0; i < 4; i++) begin
            full[i]         = (cnt_q[i] == CNT_FULL);
            empty[i]        = (cnt_q[i] == '0);
            almost_full[i]  = (cnt_q[i] >= CNT_AF);
            almost_empty[i] = (cnt_q[i] <= CNT_AE);
        end
    end

    assign pause     = |almost_full;
    assign dataOut0  = dout_q[0];
    assign dataOut1  = dout_q[1];
    assign dataOut2  = dout_q[2];
    assign dataOut3  = dout_q[3];
    assign validOut0 = valid_q[0];
    assign validOut1 = valid_q[1];
    assign validOut2 = valid_q[2];
    assign validOut3 = valid_q[3];

`ifdef FIFO_ERR_DETECT_EN
    logic [3:0] err_q;
    logic [3:0] err_d;

    // Sticky until reset: dropped pushes and ignored pops.
    always_comb begin
        err_d = err_q | (push & ~push_ok) | (pop & ~pop_ok);
    end

    always_ff @(posedge clk_1 or negedge reset_L) begin
        if (!reset_L) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 4'b0000;
`endif

endmodule

// File: tb/tb_fifo_lanes4.sv
// tb/tb_fifo_lanes4.sv - queue-model bench for fifo_lanes4 with directed and random stimulus
module tb_fifo_lanes4;
    logic       clk_1 = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] dataIn0 = '0, dataIn1 = '0, dataIn2 = '0, dataIn3 = '0;
    logic       push0 = 0, push1 = 0, push2 = 0, push3 = 0;
    logic       pop0 = 0, pop1 = 0, pop2 = 0, pop3 = 0;
    logic [7:0] dataOut0, dataOut1, dataOut2, dataOut3;
    logic       validOut0, validOut1, validOut2, validOut3;
    logic [3:0] full, empty, almost_full, almost_empty, err;
    logic       pause;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    fifo_lanes4 dut (
        .clk_1(clk_1), .reset_L(reset_L),
        .dataIn0(dataIn0), .dataIn1(dataIn1), .dataIn2(dataIn2), .dataIn3(dataIn3),
        .push0(push0), .push1(push1), .push2(push2), .push3(push3),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .dataOut0(dataOut0), .dataOut1(dataOut1), .dataOut2(dataOut2), .dataOut3(dataOut3),
        .validOut0(validOut0), .validOut1(validOut1), .validOut2(validOut2), .validOut3(validOut3),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .pause(pause), .err(err)
    );

    always #5 clk_1 = ~clk_1;

    // Reference model: one queue per lane, capacity 4.
    logic [7:0] q [4][$];
    logic [7:0] m_dout [4];
    logic [3:0] m_valid;
    logic [3:0] m_err;

    always @(posedge clk_1 or negedge reset_L) begin
        logic [3:0] pu, po;
        logic [7:0] di [4];
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                q[i].delete();
                m_dout[i] = '0;
            end
            m_valid = '0;
            m_err   = '0;
        end else begin
            pu = {push3, push2, push1, push0};
            po = {pop3, pop2, pop1, pop0};
            di[0] = dataIn0; di[1] = dataIn1; di[2] = dataIn2; di[3] = dataIn3;
            for (int i = 0; i < 4; i++) begin
                bit pop_taken, push_taken;
                pop_taken  = po[i] && (q[i].size() > 0);
                push_taken = pu[i] && (q[i].size() < 4 || pop_taken);
                m_valid[i] = pop_taken;
                if (pop_taken) m_dout[i] = q[i].pop_front();
                if (push_taken) q[i].push_back(di[i]);
                if ((pu[i] && !push_taken) || (po[i] && !pop_taken)) m_err[i] = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_1) begin
        if (cmp_en) begin
            logic [3:0] e_full, e_empty, e_af, e_ae;
            for (int i = 0; i < 4; i++) begin
                e_full[i]  = (q[i].size() == 4);
                e_empty[i] = (q[i].size() == 0);
                e_af[i]    = (q[i].size() >= 3);
                e_ae[i]    = (q[i].size() <= 1);
            end
            chk("m_dout0", {24'h0, dataOut0}, {24'h0, m_dout[0]});
            chk("m_dout1", {24'h0, dataOut1}, {24'h0, m_dout[1]});
            chk("m_dout2", {24'h0, dataOut2}, {24'h0, m_dout[2]});
            chk("m_dout3", {24'h0, dataOut3}, {24'h0, m_dout[3]});
            chk("m_valid", {28'h0, validOut3, validOut2, validOut1, validOut0}, {28'h0, m_valid});
            chk("m_full", {28'h0, full}, {28'h0, e_full});
            chk("m_empty", {28'h0, empty}, {28'h0, e_empty});
            chk("m_af", {28'h0, almost_full}, {28'h0, e_af});
            chk("m_ae", {28'h0, almost_empty}, {28'h0, e_ae});
            chk("m_pause", {31'h0, pause}, {31'h0, |e_af});
`ifdef FIFO_ERR_DETECT_EN
            chk("m_err", {28'h0, err}, {28'h0, m_err});
`else
            chk("m_err", {28'h0, err}, 32'h0);
`endif
        end
    end

    task automatic step(input logic [3:0] pu, input logic [3:0] po, input logic [7:0] d);
        {push3, push2, push1, push0} = pu;
        {pop3, pop2, pop1, pop0}     = po;
        dataIn0 = d; dataIn1 = d; dataIn2 = d; dataIn3 = d;
        @(posedge clk_1);
        #1;
    endtask

    initial begin
        logic [7:0] exp_list [4];

        // Reset held for two cycles.
        reset_L = 1'b0;
        repeat (2) @(posedge clk_1);
        #1;
        reset_L = 1'b1;
        #1;
        chk("rst_dout", {dataOut3, dataOut2, dataOut1, dataOut0}, 32'h0);
        chk("rst_valid", {28'h0, validOut3, validOut2, validOut1, validOut0}, 32'h0);
        chk("rst_empty", {28'h0, empty}, 32'hF);
        chk("rst_ae", {28'h0, almost_empty}, 32'hF);
        chk("rst_full", {28'h0, full}, 32'h0);
        chk("rst_pause", {31'h0, pause}, 32'h0);
        chk("rst_err", {28'h0, err}, 32'h0);
        @(posedge clk_1);
        #1;
        cmp_en = 1;

        // Ordering on lane 0.
        step(4'b0001, 4'b0000, 8'hFF);
        step(4'b0001, 4'b0000, 8'hBB);
        step(4'b0000, 4'b0001, 8'h00);
        chk("ord_d0", {24'h0, dataOut0}, 32'hFF);
        chk("ord_v0", {31'h0, validOut0}, 32'h1);
        step(4'b0000, 4'b0001, 8'h00);
        chk("ord_d1", {24'h0, dataOut0}, 32'hBB);
        chk("ord_v1", {31'h0, validOut0}, 32'h1);
        step(4'b0000, 4'b0000, 8'h00);
        chk("ord_vdrop", {31'h0, validOut0}, 32'h0);
        chk("ord_empty", {31'h0, empty[0]}, 32'h1);

        // Overflow on lane 1.
        step(4'b0010, 4'b0000, 8'hEE);
        step(4'b0010, 4'b0000, 8'hAA);
        step(4'b0010, 4'b0000, 8'h99);
        chk("ovf_af", {31'h0, almost_full[1]}, 32'h1);
        chk("ovf_pause", {31'h0, pause}, 32'h1);
        chk("ovf_notfull", {31'h0, full[1]}, 32'h0);
        step(4'b0010, 4'b0000, 8'h88);
        chk("ovf_full", {31'h0, full[1]}, 32'h1);
        step(4'b0010, 4'b0000, 8'h77);
`ifdef FIFO_ERR_DETECT_EN
        chk("ovf_err", {31'h0, err[1]}, 32'h1);
`else
        chk("ovf_err", {31'h0, err[1]}, 32'h0);
`endif
        exp_list = '{8'hEE, 8'hAA, 8'h99, 8'h88};
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 4'b0010, 8'h00);
            chk("ovf_pop", {24'h0, dataOut1}, {24'h0, exp_list[k]});
        end
        step(4'b0000, 4'b0000, 8'h00);
        chk("ovf_empty", {31'h0, empty[1]}, 32'h1);

        // Full lane 2 with simultaneous push and pop.
        exp_list = '{8'hDD, 8'h99, 8'h77, 8'hCC};
        for (int k = 0; k < 4; k++) step(4'b0100, 4'b0000, exp_list[k]);
        step(4'b0100, 4'b0100, 8'h11);
        chk("sim_dout", {24'h0, dataOut2}, 32'hDD);
        chk("sim_valid", {31'h0, validOut2}, 32'h1);
        chk("sim_full", {31'h0, full[2]}, 32'h1);
        exp_list = '{8'h99, 8'h77, 8'hCC, 8'h11};
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 4'b0100, 8'h00);
            chk("sim_pop", {24'h0, dataOut2}, {24'h0, exp_list[k]});
        end

        // Empty lane 3: push and pop together, no fall-through.
        step(4'b1000, 4'b1000, 8'h88);
        chk("emp_valid", {31'h0, validOut3}, 32'h0);
        chk("emp_notempty", {31'h0, empty[3]}, 32'h0);
        step(4'b0000, 4'b1000, 8'h00);
        chk("emp_pop", {24'h0, dataOut3}, 32'h88);
        chk("emp_pop_v", {31'h0, validOut3}, 32'h1);
        step(4'b0000, 4'b1000, 8'h00);
        chk("emp_under_v", {31'h0, validOut3}, 32'h0);
        chk("emp_hold", {24'h0, dataOut3}, 32'h88);
`ifdef FIFO_ERR_DETECT_EN
        chk("emp_err", {31'h0, err[3]}, 32'h1);
`else
        chk("emp_err", {31'h0, err[3]}, 32'h0);
`endif
        step(4'b0000, 4'b0000, 8'h00);

        // Randomized traffic with model comparison every cycle.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] pu, po;
            int bias;
            bias = (c / 300) % 3;
            for (int i = 0; i < 4; i++) begin
                pu[i] = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
                po[i] = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
            end
            {push3, push2, push1, push0} = pu;
            {pop3, pop2, pop1, pop0}     = po;
            dataIn0 = 8'($urandom); dataIn1 = 8'($urandom);
            dataIn2 = 8'($urandom); dataIn3 = 8'($urandom);
            @(posedge clk_1);
            #1;
        end
        step(4'b0000, 4'b0000, 8'h00);
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b1111, 8'h00);

        // Mid-operation reset with a pop in flight on lane 0.
        for (int k = 0; k < 3; k++) step(4'b0001, 4'b0000, 8'h30 + 8'(k));
        {pop3, pop2, pop1, pop0} = 4'b0001;
        @(posedge clk_1);
        #2;
        reset_L = 1'b0;
        #1;
        chk("mrst_dout0", {24'h0, dataOut0}, 32'h0);
        chk("mrst_valid", {28'h0, validOut3, validOut2, validOut1, validOut0}, 32'h0);
        chk("mrst_empty", {28'h0, empty}, 32'hF);
        chk("mrst_err", {28'h0, err}, 32'h0);
        {pop3, pop2, pop1, pop0} = 4'b0000;
        @(posedge clk_1);
        #1;
        reset_L = 1'b1;
        step(4'b0000, 4'b0000, 8'h00);
        chk("mrst_after_empty0", {31'h0, empty[0]}, 32'h1);
        chk("mrst_after_v0", {31'h0, validOut0}, 32'h0);

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_lanes4.md
# fifo_lanes4

Four-lane FIFO bank directly downstream of the recirculator. It captures the forward outputs (lanes 4–7 of the recirculator, renumbered 0–3 here) whenever their valid is high and buffers each lane independently until the next stage pops it. It produces per-lane status flags and one aggregate `pause` for upstream flow control. Single clock domain, same clock as the recirculator (`clk_1`).

## Interface
Parameters:
- `DATA_W`, 8: lane data width.
- `DEPTH`, 4: entries per lane. Must be a power of two and at least 2.
- `AF_TH`, 3: almost-full threshold. Must be between 1 and DEPTH.
- `AE_TH`, 1: almost-empty threshold. Must be between 0 and DEPTH-1.

Ports:
- `clk_1`  in  1  clock; all state changes on the rising edge.
- `reset_L`  in  1  asynchronous reset, active low.
- `dataIn0`..`dataIn3`  in  DATA_W each  lane write data, driven by recirculator `dataOut4`..`dataOut7`.
- `push0`..`push3`  in  1 each  lane write strobe, driven by recirculator `validOut4`..`validOut7`.
- `pop0`..`pop3`  in  1 each  lane read request from the downstream consumer.
- `dataOut0`..`dataOut3`  out  DATA_W each  registered read data.
- `validOut0`..`validOut3`  out  1 each  high for exactly one cycle per successful pop.
- `full`, `empty`  out  4 each  per-lane status; bit i is lane i.
- `almost_full`, `almost_empty`  out  4 each  per-lane threshold flags.
- `pause`  out  1  OR of all `almost_full` bits.
- `err`  out  4  per-lane overflow/underflow flag (see Configuration).

## Operation
- Each lane is an independent circular buffer with:
  - write pointer and read pointer, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - an occupancy counter `cnt` of log2(DEPTH)+1 bits, range 0..DEPTH.
- Push:
  - Accepted when `push` is high and (`cnt` < DEPTH, or a pop is accepted on the same lane in the same cycle).
  - Data is written at the write pointer, then the write pointer increments.
  - A push while full with no pop is dropped; the pointer and `cnt` are unchanged.
- Pop:
  - Accepted when `pop` is high and `cnt` > 0.
  - The entry at the read pointer is loaded into `dataOut`, `validOut` goes high, and the read pointer increments.
  - A pop while empty is ignored: `validOut`=0 and `dataOut` holds its previous value.
- Simultaneous push and pop:
  - Full lane: both are accepted and `cnt` stays at DEPTH.
  - Empty lane: only the push is accepted. The pop returns nothing (no fall-through), and `cnt` becomes 1.
- Counter update: `cnt` changes by +1 for a push only, -1 for a pop only, 0 for both.
- Flags are combinational from `cnt`:
  - `full` = (`cnt`==DEPTH); `empty` = (`cnt`==0);
  - `almost_full` = (`cnt`>=AF_TH); `almost_empty` = (`cnt`<=AE_TH).
- Lanes never interact, except that all lanes feed the `pause` OR.

## Timing
- Reset (`reset_L`=0, asynchronous): pointers, `cnt`, `dataOut`* and `validOut`* all go to 0; `err`=0. After reset: `empty`=4'hF, `almost_empty`=4'hF, `full`=0, `almost_full`=0, `pause`=0.
- Reset asserted mid-operation discards all stored data immediately. There is no drain.
- Write latency: a push at edge n is visible in the flags after edge n.
- Read latency: 1 cycle. A pop sampled at edge n gives `dataOut`/`validOut` valid after edge n; `validOut` drops after edge n+1 unless another pop is accepted.
- Back-to-back pops on a lane with `cnt`≥2 give one word per cycle.
- `pause` is combinational from registered `cnt`, with no extra cycle. Upstream must stop pushing the cycle after it sees `pause`=1. With AF_TH=3 and DEPTH=4 this leaves one entry of slack.

## Configuration
- `FIFO_ERR_DETECT_EN` defined:
  - `err[i]` sets on a dropped push (full, no pop) or an ignored pop (empty) on lane i.
  - Once set, it stays set until `reset_L` is asserted.
- Not defined: `err` is tied to 4'b0000 and no detection logic is generated. Data-path behaviour is identical in both builds.

## Test plan
- Reset check: hold `reset_L`=0 for 2 cycles, then release. Required: every `dataOut`=0, every `validOut`=0, `empty`=4'hF, `almost_empty`=4'hF, `pause`=0.
- Ordering: push FF then BB on lane 0, then pop twice back-to-back. Required: `dataOut0`=FF and then BB on consecutive cycles, `validOut0` high for 2 cycles, and afterwards `empty[0]`=1.
- Overflow: push EE, AA, 99, 88, 77 on lane 1 with no pops. Required:
  - after the 3rd push: `almost_full[1]`=1 and `pause`=1;
  - after the 4th push: `full[1]`=1;
  - the 77 push is dropped, and `err[1]`=1 with the macro defined;
  - four pops return EE, AA, 99, 88.
- Simultaneous push and pop on a full lane 2 (holding DD, 99, 77, CC) while pushing 11. Required: `dataOut2`=DD, `cnt` stays 4, and the following pops return 99, 77, CC, 11.
- Empty-lane corner: on empty lane 3, push 88 and pop in the same cycle. Required: `validOut3`=0 that cycle and `empty[3]`=0; the next pop returns 88. Separately, a pop on an empty lane sets `err[3]` when the macro is defined.
- Reset mid-operation: with 3 entries in lane 0 and a pop in flight, assert `reset_L` between clock edges. Required: outputs clear immediately, and after release `empty[0]`=1.
